// File: rtl/rr_requester.sv
// rr_requester: client end of a round-robin arbiter handshake.
// Jobs are queued in a circular FIFO; while work is pending the block
// raises out_request, sends at most QUANTUM words per grant, then drops
// request for one cycle so the arbiter can rotate to another client.
// Optional feature macro: RR_REQ_OVERFLOW_FLAG_EN adds a sticky
// out_overflow flag that records any push discarded on a full FIFO.
module rr_requester #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned QUANTUM = 4
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic                     in_push,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_full,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     out_request,
  input  logic                     in_grant,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data
`ifdef RR_REQ_OVERFLOW_FLAG_EN
  ,
  output logic                     out_overflow
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned QNT_W = $clog2(QUANTUM + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_XFER  = 2'd2,
    S_YIELD = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_d;
  logic [QNT_W-1:0]   qcnt_q, qcnt_d;
  logic               full_d;
  logic               request_d;
  logic               valid_d;
  logic [DATA_W-1:0]  data_d;
  logic               push_ok;
  logic               pop;
  logic [DATA_W-1:0]  mem [DEPTH];

  // Next-state, FIFO pointer and registered-output computation
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    qcnt_d   = qcnt_q;
    valid_d  = 1'b0;
    data_d   = out_data;
    pop      = 1'b0;
    // A push against a full FIFO is dropped even if a pop happens at the same edge
    push_ok  = in_push && !out_full;

    case (state_q)
      S_IDLE: begin
        if (out_count != '0) state_d = S_REQ;
      end
      S_REQ: begin
        if (in_grant) begin
          state_d = S_XFER;
          qcnt_d  = '0;
        end
      end
      S_XFER: begin
        if (!in_grant) begin
          // Preempted: keep requesting, no pop this edge
          state_d = S_REQ;
        end else if (out_count == '0) begin
          state_d = S_YIELD;
        end else begin
          pop    = 1'b1;
          qcnt_d = qcnt_q + 1'b1;
          if ((qcnt_d == QNT_W'(QUANTUM)) ||
              ((out_count == CNT_W'(1)) && !push_ok)) begin
            state_d = S_YIELD;
          end
        end
      end
      S_YIELD: begin
        state_d = (out_count != '0) ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push_ok) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
    if (pop) begin
      rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
      valid_d  = 1'b1;
      data_d   = mem[rd_ptr_q];
    end

    count_d   = out_count + CNT_W'(push_ok) - CNT_W'(pop);
    full_d    = (count_d == CNT_W'(DEPTH));
    request_d = (state_d == S_REQ) || (state_d == S_XFER);
  end

  // State, pointers and output registers
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      qcnt_q      <= '0;
      out_count   <= '0;
      out_full    <= 1'b0;
      out_request <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      qcnt_q      <= qcnt_d;
      out_count   <= count_d;
      out_full    <= full_d;
      out_request <= request_d;
      out_valid   <= valid_d;
      out_data    <= data_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge in_clk) begin
    if (push_ok) mem[wr_ptr_q] <= in_data;
  end

`ifdef RR_REQ_OVERFLOW_FLAG_EN
  // Sticky record of any push discarded on a full FIFO
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      out_overflow <= 1'b0;
    end else if (in_push && out_full) begin
      out_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/rr_requester.md
RR_REQUESTER -- requirements
Module: rr_requester

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DATA_W, 8, job word width in bits.
- DEPTH, 4, job FIFO depth in words; power of two, at least 2.
- QUANTUM, 4, maximum words sent per grant; at least 1.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- in_clk, input, 1, sole clock; all state changes on the rising edge.
- in_reset, input, 1, asynchronous active-low reset.
- in_push, input, 1, load in_data into the FIFO.
- in_data, input, DATA_W, job word.
- out_full, output, 1, FIFO holds DEPTH words.
- out_count, output, clog2(DEPTH)+1, FIFO occupancy.
- out_request, output, 1, request line to the round-robin arbiter.
- in_grant, input, 1, this client's bit of the arbiter grant vector.
- out_valid, output, 1, out_data carries a transmitted word this cycle.
- out_data, output, DATA_W, transmitted word.

Function
REQ-003 The block SHALL be the client end of the arbiter handshake: hold request while work is pending, send at most QUANTUM words per grant, then drop request so the arbiter rotates.
REQ-004 The FIFO SHALL be circular, with read and write pointers that wrap from DEPTH-1 to 0.
REQ-005 A push with out_full=1 at the clock edge SHALL be discarded, and FIFO contents SHALL remain unchanged.
REQ-006 A push and a pop at the same edge SHALL both take effect, leaving out_count unchanged; this applies on a full FIFO only if the push is accepted per REQ-005, so it is dropped.
REQ-007 The state machine SHALL have four states: IDLE, REQ, XFER and YIELD.
REQ-008 In IDLE, out_request SHALL be 0; the machine SHALL go to REQ at the edge where out_count is non-zero.
REQ-009 In REQ, out_request SHALL be 1; when in_grant=1 the machine SHALL go to XFER, clear the quantum counter, and perform no pop at that edge.
REQ-010 In XFER, out_request SHALL be 1.
- At each edge with in_grant=1 and a non-empty FIFO, the block SHALL pop the head, register it into out_data, set out_valid=1 for the following cycle, and increment the quantum counter.
- out_valid SHALL be 0 in every other cycle.
REQ-011 XFER SHALL go to YIELD at the pop edge where the quantum counter reaches QUANTUM or the FIFO becomes empty.
REQ-012 If in_grant falls during XFER (preemption), the block SHALL perform no pop at that edge and SHALL return to REQ with out_request held at 1.
REQ-013 YIELD SHALL last exactly one cycle with out_request=0, then go to REQ if out_count is non-zero, else IDLE.
REQ-014 Words SHALL leave in strict push order, and at most QUANTUM out_valid pulses SHALL occur between consecutive YIELD states.

Reset
REQ-015 While in_reset=0, independent of in_clk, the block SHALL force:
- state=IDLE, pointers=0, out_count=0, quantum counter=0;
- out_full=0, out_request=0, out_valid=0, out_data=0.
REQ-016 Reset asserted mid-XFER SHALL discard all queued words.
REQ-017 After reset release, the first active edge SHALL follow normal IDLE rules.

Configuration
REQ-018 When macro RR_REQ_OVERFLOW_FLAG_EN is defined:
- the block SHALL add output out_overflow, width 1;
- out_overflow SHALL be set on any push discarded per REQ-005;
- out_overflow SHALL be sticky until reset, with reset value 0.
REQ-019 Without RR_REQ_OVERFLOW_FLAG_EN, out_overflow SHALL be absent and discarded pushes SHALL be silent.

Verification (DATA_W=8, DEPTH=4, QUANTUM=2 unless stated)
REQ-020 Push 0x11 then 0x22, with grant given one cycle after request -> out_request rises one cycle after the first push; out_valid pulses 0x11 then 0x22 on consecutive cycles; then YIELD, then IDLE.
REQ-021 Push 0xA1, 0xA2, 0xA3 with in_grant held high -> 0xA1, 0xA2, one YIELD cycle with out_request=0, REQ, then 0xA3.
REQ-022 Push five words back-to-back with no grant -> out_full=1 after the fourth push; the fifth word is never transmitted; with the macro defined, out_overflow=1.
REQ-023 Drop in_grant after the first word of a two-word burst -> no pop at that edge; out_request stays 1; on re-grant the second word is sent.
REQ-024 Assert in_reset=0 mid-XFER between clock edges -> all outputs are 0 immediately; after release, out_count=0 and the state is IDLE.
REQ-025 Push and grant-pop at the same edge with a three-word FIFO -> out_count stays 3; pointer wrap over 8+ words preserves order.
